// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and register-match helper for the integer pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    // Architectural $0: reads as zero, never a forwarding source.
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;

    // Registered ID/EX control bundle.
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  imm;
    } id_ex_ctl_t;

    // A writer matches a reader only if it writes, targets a real register, and the addresses agree.
    function automatic logic reg_match(input logic we,
                                       input logic [REG_AW-1:0] wr_addr,
                                       input logic [REG_AW-1:0] rd_addr);
        return we && (wr_addr != REG_ZERO) && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding selector: youngest matching producer wins over the stored value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; loads in EX/MEM are never a source since their data is not ready.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              exmem_we_i,
    input  logic              exmem_is_load_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_we_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] val_o
);

    // Priority select: EX/MEM (non-load), then MEM/WB, then the stored operand.
    always_comb begin
        val_o = stored_i;
        if (reg_match(exmem_we_i && !exmem_is_load_i, exmem_rd_i, addr_i)) begin
            val_o = exmem_data_i;
        end else if (reg_match(memwb_we_i, memwb_rd_i, addr_i)) begin
            val_o = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through capture bypass, EX-time forwarding and load-use detection.
// Latency: 1 cycle ID->EX for controls/operands; 0 cycles through the forwarding muxes.
// Backpressure: Stall freezes the register (operands still refreshed from MEM/WB); LoadUseHazard asks upstream to hold.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               IdValid,
    input  logic [REG_AW-1:0]  IdRsAddr,
    input  logic [REG_AW-1:0]  IdRtAddr,
    input  logic               IdUsesRt,
    input  logic [REG_AW-1:0]  IdRdAddr,
    input  logic               IdRegWrite,
    input  logic               IdMemRead,
    input  logic [ALUOP_W-1:0] IdAluOp,
    input  logic [DATA_W-1:0]  IdImm,
    input  logic [DATA_W-1:0]  RsData,
    input  logic [DATA_W-1:0]  RtData,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ExMemRegWrite,
    input  logic               ExMemIsLoad,
    input  logic [REG_AW-1:0]  ExMemRd,
    input  logic [DATA_W-1:0]  ExMemResult,
    input  logic               MemWbRegWrite,
    input  logic [REG_AW-1:0]  MemWbRd,
    input  logic [DATA_W-1:0]  MemWbData,
    output logic               ExValid,
    output logic               ExRegWrite,
    output logic               ExMemRead,
    output logic [REG_AW-1:0]  ExRsAddr,
    output logic [REG_AW-1:0]  ExRtAddr,
    output logic [REG_AW-1:0]  ExRdAddr,
    output logic [ALUOP_W-1:0] ExAluOp,
    output logic [DATA_W-1:0]  ExImm,
    output logic [DATA_W-1:0]  ExOpA,
    output logic [DATA_W-1:0]  ExOpB,
    output logic               LoadUseHazard
);

    id_ex_ctl_t        ctl_q, ctl_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d;
    logic [DATA_W-1:0] rt_val_q, rt_val_d;

    // Operand candidates: fresh capture (write-through) and held value refreshed during a stall.
    logic [DATA_W-1:0] rs_cap, rt_cap, rs_hold, rt_hold;

    // The register file writes on the same edge we capture, so its read data is stale on a MEM/WB match.
    fwd_mux u_cap_rs (
        .addr_i(IdRsAddr), .stored_i(RsData),
        .exmem_we_i(1'b0), .exmem_is_load_i(1'b0), .exmem_rd_i(REG_ZERO), .exmem_data_i('0),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(rs_cap)
    );
    fwd_mux u_cap_rt (
        .addr_i(IdRtAddr), .stored_i(RtData),
        .exmem_we_i(1'b0), .exmem_is_load_i(1'b0), .exmem_rd_i(REG_ZERO), .exmem_data_i('0),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(rt_cap)
    );

    // A producer retiring while we are frozen would otherwise never reach the held operand.
    fwd_mux u_hold_rs (
        .addr_i(ctl_q.rs), .stored_i(rs_val_q),
        .exmem_we_i(1'b0), .exmem_is_load_i(1'b0), .exmem_rd_i(REG_ZERO), .exmem_data_i('0),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(rs_hold)
    );
    fwd_mux u_hold_rt (
        .addr_i(ctl_q.rt), .stored_i(rt_val_q),
        .exmem_we_i(1'b0), .exmem_is_load_i(1'b0), .exmem_rd_i(REG_ZERO), .exmem_data_i('0),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(rt_hold)
    );

    // EX-time operand forwarding from the two younger stages.
    fwd_mux u_ex_a (
        .addr_i(ctl_q.rs), .stored_i(rs_val_q),
        .exmem_we_i(ExMemRegWrite), .exmem_is_load_i(ExMemIsLoad), .exmem_rd_i(ExMemRd), .exmem_data_i(ExMemResult),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(ExOpA)
    );
    fwd_mux u_ex_b (
        .addr_i(ctl_q.rt), .stored_i(rt_val_q),
        .exmem_we_i(ExMemRegWrite), .exmem_is_load_i(ExMemIsLoad), .exmem_rd_i(ExMemRd), .exmem_data_i(ExMemResult),
        .memwb_we_i(MemWbRegWrite), .memwb_rd_i(MemWbRd), .memwb_data_i(MemWbData),
        .val_o(ExOpB)
    );

    // A load in EX cannot forward in time to a dependent instruction in ID; $0 never creates a dependency.
    assign LoadUseHazard = ctl_q.valid && ctl_q.mem_read && IdValid &&
                           (ctl_q.rd != REG_ZERO) &&
                           ((ctl_q.rd == IdRsAddr) || (IdUsesRt && (ctl_q.rd == IdRtAddr)));

    // Next-state select: flush > stall > load-use bubble > normal capture.
    always_comb begin
        ctl_d    = ctl_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        if (Flush) begin
            ctl_d.valid     = 1'b0;
            ctl_d.reg_write = 1'b0;
            ctl_d.mem_read  = 1'b0;
        end else if (Stall) begin
            rs_val_d = rs_hold;
            rt_val_d = rt_hold;
        end else if (LoadUseHazard) begin
            ctl_d.valid     = 1'b0;
            ctl_d.reg_write = 1'b0;
            ctl_d.mem_read  = 1'b0;
        end else begin
            ctl_d.valid     = IdValid;
            ctl_d.reg_write = IdRegWrite;
            ctl_d.mem_read  = IdMemRead;
            ctl_d.rs        = IdRsAddr;
            ctl_d.rt        = IdRtAddr;
            ctl_d.rd        = IdRdAddr;
            ctl_d.alu_op    = IdAluOp;
            ctl_d.imm       = IdImm;
            rs_val_d        = rs_cap;
            rt_val_d        = rt_cap;
        end
    end

    // Pipeline register; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q    <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
        end else begin
            ctl_q    <= ctl_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
        end
    end

    assign ExValid    = ctl_q.valid;
    assign ExRegWrite = ctl_q.reg_write;
    assign ExMemRead  = ctl_q.mem_read;
    assign ExRsAddr   = ctl_q.rs;
    assign ExRtAddr   = ctl_q.rt;
    assign ExRdAddr   = ctl_q.rd;
    assign ExAluOp    = ctl_q.alu_op;
    assign ExImm      = ctl_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX boundary register: forwarding, bypass, hazards, stall/flush, async reset.
// Latency: checks registered outputs 1 ns after the edge, combinational outputs 1 ns after an input change.
// Backpressure: Stall/Flush driven directly by the stimulus.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               IdValid;
    logic [REG_AW-1:0]  IdRsAddr, IdRtAddr, IdRdAddr;
    logic               IdUsesRt, IdRegWrite, IdMemRead;
    logic [ALUOP_W-1:0] IdAluOp;
    logic [DATA_W-1:0]  IdImm, RsData, RtData;
    logic               Stall, Flush;
    logic               ExMemRegWrite, ExMemIsLoad;
    logic [REG_AW-1:0]  ExMemRd;
    logic [DATA_W-1:0]  ExMemResult;
    logic               MemWbRegWrite;
    logic [REG_AW-1:0]  MemWbRd;
    logic [DATA_W-1:0]  MemWbData;
    logic               ExValid, ExRegWrite, ExMemRead;
    logic [REG_AW-1:0]  ExRsAddr, ExRtAddr, ExRdAddr;
    logic [ALUOP_W-1:0] ExAluOp;
    logic [DATA_W-1:0]  ExImm, ExOpA, ExOpB;
    logic               LoadUseHazard;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .IdValid(IdValid), .IdRsAddr(IdRsAddr), .IdRtAddr(IdRtAddr), .IdUsesRt(IdUsesRt),
        .IdRdAddr(IdRdAddr), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdAluOp(IdAluOp), .IdImm(IdImm), .RsData(RsData), .RtData(RtData),
        .Stall(Stall), .Flush(Flush),
        .ExMemRegWrite(ExMemRegWrite), .ExMemIsLoad(ExMemIsLoad), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExRsAddr(ExRsAddr), .ExRtAddr(ExRtAddr), .ExRdAddr(ExRdAddr),
        .ExAluOp(ExAluOp), .ExImm(ExImm), .ExOpA(ExOpA), .ExOpB(ExOpB),
        .LoadUseHazard(LoadUseHazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IdValid = 0; IdRsAddr = 0; IdRtAddr = 0; IdUsesRt = 0; IdRdAddr = 0;
        IdRegWrite = 0; IdMemRead = 0; IdAluOp = 0; IdImm = 0; RsData = 0; RtData = 0;
        Stall = 0; Flush = 0;
        ExMemRegWrite = 0; ExMemIsLoad = 0; ExMemRd = 0; ExMemResult = 0;
        MemWbRegWrite = 0; MemWbRd = 0; MemWbData = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic [3:0] op,
                          input logic [31:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
        IdValid = v; IdRsAddr = rs; IdRtAddr = rt; IdUsesRt = urt; IdRdAddr = rd;
        IdRegWrite = rw; IdMemRead = mr; IdAluOp = op; IdImm = imm; RsData = rsd; RtData = rtd;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(ExValid), 32'h0);
        check("rst_rd", 32'(ExRdAddr), 32'h0);
        check("rst_imm", ExImm, 32'h0);
        check("rst_opa", ExOpA, 32'h0);
        check("rst_opb", ExOpB, 32'h0);
        check("rst_hazard", 32'(LoadUseHazard), 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // Back-to-back ALU forwarding.
        set_id(1, 5'd3, 5'd2, 1, 5'd4, 1, 0, ALU_SUB, 32'h7, 32'h1, 32'h2);
        tick();
        check("alu_valid", 32'(ExValid), 32'h1);
        check("alu_rd", 32'(ExRdAddr), 32'h4);
        check("alu_imm", ExImm, 32'h7);
        check("alu_op", 32'(ExAluOp), 32'(ALU_SUB));
        check("alu_rw", 32'(ExRegWrite), 32'h1);
        check("alu_opa_plain", ExOpA, 32'h1);
        check("alu_opb_plain", ExOpB, 32'h2);
        ExMemRegWrite = 1; ExMemRd = 5'd3; ExMemResult = 32'h10;
        #1 check("fwd_exmem", ExOpA, 32'h10);
        MemWbRegWrite = 1; MemWbRd = 5'd3; MemWbData = 32'h20;
        #1 check("fwd_exmem_prio", ExOpA, 32'h10);
        ExMemIsLoad = 1;
        #1 check("fwd_load_skipped", ExOpA, 32'h20);
        ExMemRegWrite = 0; ExMemIsLoad = 0; MemWbRd = 5'd2; MemWbData = 32'h30;
        #1 check("fwd_memwb_b", ExOpB, 32'h30);
        check("fwd_memwb_a_none", ExOpA, 32'h1);

        // Load-use hazard and bubble.
        clear_inputs();
        set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, ALU_ADD, 32'h4, 32'h100, 32'h0);
        tick();
        check("lw_memread", 32'(ExMemRead), 32'h1);
        set_id(1, 5'd5, 5'd6, 1, 5'd8, 1, 0, ALU_ADD, 32'h0, 32'h999, 32'h66);
        #1 check("lu_hazard_rs", 32'(LoadUseHazard), 32'h1);
        IdValid = 0;
        #1 check("lu_no_idvalid", 32'(LoadUseHazard), 32'h0);
        IdValid = 1; IdRsAddr = 5'd7; IdRtAddr = 5'd5; IdUsesRt = 0;
        #1 check("lu_rt_unused", 32'(LoadUseHazard), 32'h0);
        IdUsesRt = 1;
        #1 check("lu_rt_used", 32'(LoadUseHazard), 32'h1);
        IdRsAddr = 5'd5; IdRtAddr = 5'd6;
        tick();
        check("bubble_valid", 32'(ExValid), 32'h0);
        check("bubble_rw", 32'(ExRegWrite), 32'h0);
        check("bubble_mr", 32'(ExMemRead), 32'h0);
        check("bubble_hazard_clear", 32'(LoadUseHazard), 32'h0);
        ExMemRegWrite = 1; ExMemIsLoad = 1; ExMemRd = 5'd5; ExMemResult = 32'hDEAD;
        tick();
        ExMemRegWrite = 0; ExMemIsLoad = 0; ExMemRd = 0; ExMemResult = 0;
        MemWbRegWrite = 1; MemWbRd = 5'd5; MemWbData = 32'hABCD;
        #1 check("lu_consumer_valid", 32'(ExValid), 32'h1);
        check("lu_consumer_opa", ExOpA, 32'hABCD);
        check("lu_consumer_opb", ExOpB, 32'h66);

        // Same-edge write-through on capture, and $0 never bypassed.
        clear_inputs();
        set_id(1, 5'd7, 5'd9, 1, 5'd1, 1, 0, ALU_OR, 32'h0, 32'h11, 32'h22);
        MemWbRegWrite = 1; MemWbRd = 5'd7; MemWbData = 32'h55;
        tick();
        MemWbRegWrite = 0; MemWbRd = 0; MemWbData = 0;
        #1 check("wt_rs", ExOpA, 32'h55);
        check("wt_rt_untouched", ExOpB, 32'h22);
        set_id(1, 5'd0, 5'd0, 1, 5'd1, 1, 0, ALU_OR, 32'h0, 32'h0, 32'h33);
        MemWbRegWrite = 1; MemWbRd = 5'd0; MemWbData = 32'h77;
        tick();
        check("wt_zero_rt", ExOpB, 32'h33);

        // Zero register never forwarded at EX.
        ExMemRegWrite = 1; ExMemRd = 5'd0; ExMemResult = 32'hFFFF;
        MemWbData = 32'hEEEE;
        #1 check("zero_no_fwd", ExOpA, 32'h0);

        // Stall holds, refreshes from MEM/WB, stall+flush kills.
        clear_inputs();
        set_id(1, 5'd4, 5'd2, 1, 5'd6, 1, 0, ALU_AND, 32'h44, 32'h40, 32'h41);
        tick();
        check("st_cap_opa", ExOpA, 32'h40);
        Stall = 1;
        set_id(1, 5'd9, 5'd8, 1, 5'd10, 1, 0, ALU_XOR, 32'h99, 32'h90, 32'h80);
        tick();
        check("st1_rd", 32'(ExRdAddr), 32'h6);
        check("st1_imm", ExImm, 32'h44);
        check("st1_opa", ExOpA, 32'h40);
        check("st1_valid", 32'(ExValid), 32'h1);
        MemWbRegWrite = 1; MemWbRd = 5'd4; MemWbData = 32'h4444;
        tick();
        MemWbRegWrite = 0; MemWbRd = 0; MemWbData = 0;
        #1 check("st2_refresh", ExOpA, 32'h4444);
        check("st2_opb", ExOpB, 32'h41);
        tick();
        check("st3_rs", 32'(ExRsAddr), 32'h4);
        check("st3_opa", ExOpA, 32'h4444);
        check("st3_op", 32'(ExAluOp), 32'(ALU_AND));
        Flush = 1;
        tick();
        check("stfl_valid", 32'(ExValid), 32'h0);
        check("stfl_rw", 32'(ExRegWrite), 32'h0);
        Stall = 0; Flush = 0;
        tick();
        check("rel_valid", 32'(ExValid), 32'h1);
        check("rel_rd", 32'(ExRdAddr), 32'hA);
        check("rel_opa", ExOpA, 32'h90);

        // Asynchronous reset between edges.
        clear_inputs();
        #3 rst_n = 1'b0;
        #1 check("arst_valid", 32'(ExValid), 32'h0);
        check("arst_rd", 32'(ExRdAddr), 32'h0);
        check("arst_imm", ExImm, 32'h0);
        check("arst_opa", ExOpA, 32'h0);
        check("arst_opb", ExOpB, 32'h0);
        set_id(1, 5'd1, 5'd0, 0, 5'd12, 1, 0, ALU_ADD, 32'h12, 32'h1234, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(ExValid), 32'h1);
        check("post_rst_rd", 32'(ExRdAddr), 32'hC);
        check("post_rst_opa", ExOpA, 32'h1234);
        check("post_rst_imm", ExImm, 32'h12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute boundary register of the static 5-stage pipeline.
- Captures decode controls plus the two register-file read operands.
- Performs write-through bypass on capture and EX-time forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards; handles stall, flush and bubble insertion.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
ALUOP_W, 4, ALU opcode width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
IdValid  in  1  decode slot holds a real instruction
IdRsAddr  in  REG_AW  source register A address
IdRtAddr  in  REG_AW  source register B address
IdUsesRt  in  1  instruction reads Rt as an operand
IdRdAddr  in  REG_AW  destination register
IdRegWrite  in  1  instruction writes a register
IdMemRead  in  1  instruction is a load
IdAluOp  in  ALUOP_W  ALU operation
IdImm  in  DATA_W  sign/zero-extended immediate
RsData  in  DATA_W  register-file read port A
RtData  in  DATA_W  register-file read port B
Stall  in  1  external freeze of ID/EX (e.g. memory wait)
Flush  in  1  kill the instruction entering EX (branch/jump redirect)
ExMemRegWrite  in  1  EX/MEM instruction writes a register
ExMemIsLoad  in  1  EX/MEM instruction is a load (its result is not yet valid)
ExMemRd  in  REG_AW  EX/MEM destination register
ExMemResult  in  DATA_W  EX/MEM ALU result
MemWbRegWrite  in  1  MEM/WB write enable (same signal that drives the register file)
MemWbRd  in  REG_AW  MEM/WB destination register
MemWbData  in  DATA_W  MEM/WB write data
ExValid, ExRegWrite, ExMemRead  out  1  registered controls
ExRsAddr, ExRtAddr, ExRdAddr  out  REG_AW  registered addresses
ExAluOp  out  ALUOP_W  registered ALU operation
ExImm  out  DATA_W  registered immediate
ExOpA, ExOpB  out  DATA_W  forwarded operands (combinational from registered values)
LoadUseHazard  out  1  combinational; upstream must hold PC and IF/ID

Behaviour:
Reset:
- rst_n low clears every register to 0 immediately, independent of clk.
- ExOpA/ExOpB then read 0.

Match rules:
- A register match needs the relevant write enable, a nonzero address, and address equality.
- Register $0 is never forwarded or bypassed.

Capture bypass:
- Value stored for Rs is MemWbData when MemWb matches IdRsAddr, otherwise RsData.
- Same rule for Rt.
- Purpose: the register file writes on the same edge, so its combinational read returns the old value.

LoadUseHazard:
- Asserted when ExValid & ExMemRead & IdValid, and ExRdAddr matches IdRsAddr, or matches IdRtAddr with IdUsesRt set.
- ExRdAddr must be nonzero.

Per-edge priority, highest first:
- Flush: ExValid, ExRegWrite and ExMemRead go to 0; the other fields are don't-care and hold.
- Stall: all fields hold. Held Rs/Rt values are still refreshed with MemWbData when MemWb matches ExRsAddr/ExRtAddr, so a writer that retires during the stall is not lost.
- LoadUseHazard: insert a bubble (same as Flush).
- Otherwise: capture all Id* inputs; ExValid <= IdValid.

EX forwarding:
- ExOpA = ExMemResult if EX/MEM matches ExRsAddr and ExMemIsLoad = 0.
- Else MemWbData if MemWb matches ExRsAddr.
- Else the stored Rs value.
- ExOpB uses the same rule with ExRtAddr.
- EX/MEM has priority over MEM/WB, giving the youngest value.
- Loads in EX/MEM are excluded. The one-cycle load-use bubble guarantees the load reaches MEM/WB before a dependent instruction consumes it.

Latency:
- Controls and operands: 1 cycle ID to EX.
- Forwarding mux: 0 cycles.

Decomposition:
- Shared package cpu_pkg holds DATA_W, REG_AW, ALUOP_W, the ALU opcode constants, and a zero-register constant.
- One natural sub-module, fwd_mux: a single operand forwarding selector (address, stored value, EX/MEM and MEM/WB ports), instantiated twice.
- The capture bypass reuses fwd_mux with its EX/MEM enable tied low.

Test Plan:
- Back-to-back ALU: add $3 in EX/MEM (ExMemResult=0x10), consumer Rs=$3 in EX -> ExOpA=0x10; with MemWb also matching $3 (0x20), still 0x10.
- Load-use: lw $5 in EX, next IdRsAddr=$5 -> LoadUseHazard=1, next ExValid=0. One cycle later MemWb writes $5=0xABCD -> consumer's ExOpA=0xABCD.
- Same-edge write-through: MemWb writes $7=0x55 while ID reads $7 with RsData=0x11 -> stored Rs=0x55.
- Zero register: ExMemRd=0, ExMemRegWrite=1, ExMemResult=0xFFFF, ExRsAddr=0 -> ExOpA = stored value 0.
- Stall/flush: Stall=1 for 3 cycles holds all outputs, and a MemWb write to $4 during the stall updates the held Rs of $4. Stall=1 together with Flush=1 -> ExValid=0.
- Async reset mid-operation: drop rst_n between edges -> all outputs 0 before the next clk edge; first edge after release captures normally.
